router_pkt_tx: RTL and testbench

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

---
 rtl/router_pkg.sv | 29 ++
 rtl/router_pkt_tx_if.sv | 36 +++
 rtl/router_parity_acc.sv | 24 ++
 rtl/router_pkt_tx.sv | 126 ++++++++++++
 tb/tb_router_pkt_tx.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types, header layout and limits for the router packet transmitter
package router_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_PARITY  = 3'd3,
    ST_DONE    = 3'd4
  } tx_state_e;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;

  localparam int MAX_PAYLOAD = 63;

  function automatic logic [7:0] make_header(input logic [5:0] len, input logic [1:0] addr);
    logic [7:0] h;
    h = '0;
    h[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
    h[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
    return h;
  endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// rtl/router_pkt_tx_if.sv - request, payload-source and router-side signals of the transmitter
// Optional port inj_par_err exists only when ROUTER_TX_PARITY_INJ_EN is defined.
interface router_pkt_tx_if;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] payload_len;
`ifdef ROUTER_TX_PARITY_INJ_EN
  logic       inj_par_err;
`endif
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       busy_in;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_busy;
  logic       done;
  logic       err;
  logic       underrun;

  modport master (
`ifdef ROUTER_TX_PARITY_INJ_EN
    output inj_par_err,
`endif
    output start, dest_addr, payload_len, pl_data, pl_valid, busy_in,
    input  pl_ready, data_out, pkt_valid, tx_busy, done, err, underrun
  );

  modport slave (
`ifdef ROUTER_TX_PARITY_INJ_EN
    input  inj_par_err,
`endif
    input  start, dest_addr, payload_len, pl_data, pl_valid, busy_in,
    output pl_ready, data_out, pkt_valid, tx_busy, done, err, underrun
  );
endinterface

// File: rtl/router_parity_acc.sv
// rtl/router_parity_acc.sv - 8-bit XOR accumulator; clear with enable loads the byte directly
module router_parity_acc (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic [7:0] byte_i,
  output logic [7:0] acc_o
);
  logic [7:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clear_i)   acc_d = en_i ? byte_i : 8'h00;
    else if (en_i) acc_d = acc_q ^ byte_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) acc_q <= 8'h00;
    else      acc_q <= acc_d;
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - sends header, payload and XOR parity byte to a router port
// Optional parity error injection via ROUTER_TX_PARITY_INJ_EN.
module router_pkt_tx
  import router_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  router_pkt_tx_if.slave tx
);
  localparam int REM_W = $clog2(MAX_PAYLOAD + 1);

  tx_state_e        state_q, state_d;
  logic [REM_W-1:0] remaining_q, remaining_d;
  logic [7:0]       data_q, data_d;
  logic             pkt_valid_q, pkt_valid_d;
  logic             err_q, err_d;
  logic             underrun_q, underrun_d;
  logic             start_ok, accept, fetch;
  logic [7:0]       hdr_byte, fetch_byte, par_byte, acc;
  logic             acc_clr, acc_en;
  logic [7:0]       acc_in;

  assign hdr_byte   = make_header(tx.payload_len, tx.dest_addr);
  assign fetch_byte = tx.pl_valid ? tx.pl_data : 8'h00;
  assign start_ok   = (state_q == ST_IDLE) && tx.start && (tx.payload_len != '0)
                      && (tx.dest_addr != ADDR_INVALID);
  assign accept     = (state_q inside {ST_HEADER, ST_PAYLOAD, ST_PARITY}) && !tx.busy_in;
  assign fetch      = accept && ((state_q == ST_HEADER) ||
                      ((state_q == ST_PAYLOAD) && (remaining_q > REM_W'(1))));

`ifdef ROUTER_TX_PARITY_INJ_EN
  logic inj_q;
  always_ff @(posedge clk) begin
    if (!rst)          inj_q <= 1'b0;
    else if (start_ok) inj_q <= tx.inj_par_err;
  end
  assign par_byte = acc ^ {8{inj_q}};
`else
  assign par_byte = acc;
`endif

  // The accumulator restarts with the header so parity covers it without an extra cycle.
  assign acc_clr = start_ok;
  assign acc_en  = start_ok || fetch;
  assign acc_in  = start_ok ? hdr_byte : fetch_byte;

  router_parity_acc u_parity (
    .clk    (clk),
    .rst    (rst),
    .clear_i(acc_clr),
    .en_i   (acc_en),
    .byte_i (acc_in),
    .acc_o  (acc)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_ok) state_d = ST_HEADER;
      ST_HEADER:  if (accept) state_d = ST_PAYLOAD;
      ST_PAYLOAD: if (accept && (remaining_q == REM_W'(1))) state_d = ST_PARITY;
      ST_PARITY:  if (accept) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d      = data_q;
    pkt_valid_d = pkt_valid_q;
    remaining_d = remaining_q;
    underrun_d  = underrun_q;
    err_d       = 1'b0;
    if ((state_q == ST_IDLE) && tx.start) begin
      if (start_ok) begin
        data_d      = hdr_byte;
        pkt_valid_d = 1'b1;
        remaining_d = tx.payload_len;
        underrun_d  = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
    if (fetch) begin
      data_d = fetch_byte;
      if (!tx.pl_valid) underrun_d = 1'b1;
    end
    if (accept && (state_q == ST_PAYLOAD)) begin
      remaining_d = remaining_q - REM_W'(1);
      if (remaining_q == REM_W'(1)) begin
        data_d      = par_byte;
        pkt_valid_d = 1'b0;
      end
    end
    if (accept && (state_q == ST_PARITY)) data_d = 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q      <= 8'h00;
      pkt_valid_q <= 1'b0;
      remaining_q <= '0;
      err_q       <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      data_q      <= data_d;
      pkt_valid_q <= pkt_valid_d;
      remaining_q <= remaining_d;
      err_q       <= err_d;
      underrun_q  <= underrun_d;
    end
  end

  assign tx.pl_ready  = rst && fetch;
  assign tx.tx_busy   = rst && (state_q != ST_IDLE);
  assign tx.done      = (state_q == ST_DONE);
  assign tx.data_out  = data_q;
  assign tx.pkt_valid = pkt_valid_q;
  assign tx.err       = err_q;
  assign tx.underrun  = underrun_q;
endmodule

// File: tb/tb_router_pkt_tx.sv
// tb/tb_router_pkt_tx.sv - scoreboard bench for router_pkt_tx
// Covers parity injection when ROUTER_TX_PARITY_INJ_EN is defined.
module tb_router_pkt_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  router_pkt_tx_if bus ();

  router_pkt_tx dut (
    .clk(clk),
    .rst(rst),
    .tx (bus)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [8:0] exp_q[$];
  logic [7:0] pay[64];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Every beat the router accepts is compared against the next expected {pkt_valid, byte}.
  always @(negedge clk) begin
    if (rst && bus.tx_busy && !bus.busy_in && !bus.done) begin
      if (exp_q.size() == 0) begin
        check_val("beat_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check_val("beat", 32'({bus.pkt_valid, bus.data_out}), 32'(e));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_data_out"},  32'(bus.data_out),  32'd0);
    check_val({tag, "_pkt_valid"}, 32'(bus.pkt_valid), 32'd0);
    check_val({tag, "_tx_busy"},   32'(bus.tx_busy),   32'd0);
    check_val({tag, "_pl_ready"},  32'(bus.pl_ready),  32'd0);
    check_val({tag, "_done"},      32'(bus.done),      32'd0);
    check_val({tag, "_err"},       32'(bus.err),       32'd0);
    check_val({tag, "_underrun"},  32'(bus.underrun),  32'd0);
  endtask

  task automatic run_pkt(input logic [1:0] addr, input logic [5:0] len, input logic inj,
                         input int stall_at, input int stall_n, input int gap_at,
                         input int abort_at);
    logic [7:0] par, b;
    int beat, stalls, guard, ilen;
    ilen = int'(len);
    par  = {len, addr};
    exp_q.push_back({1'b1, par});
    for (int i = 0; i < ilen; i++) begin
      b = (i == gap_at) ? 8'h00 : pay[i];
      exp_q.push_back({1'b1, b});
      par ^= b;
    end
    if (inj) par = ~par;
    exp_q.push_back({1'b0, par});

    bus.start       = 1'b1;
    bus.dest_addr   = addr;
    bus.payload_len = len;
`ifdef ROUTER_TX_PARITY_INJ_EN
    bus.inj_par_err = inj;
`endif
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_val("tx_busy_on", 32'(bus.tx_busy), 32'd1);

    beat = 0; stalls = 0; guard = 0;
    while (beat < ilen + 2 && guard < 500) begin
      guard++;
      if (beat == abort_at) begin
        rst = 1'b0; bus.busy_in = 1'b0; bus.start = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("mid_rst");
        rst = 1'b1;
        exp_q.delete();
        return;
      end
      bus.busy_in  = (beat == stall_at) && (stalls < stall_n);
      bus.start    = (beat == 1);
      bus.pl_data  = (beat < ilen) ? pay[beat] : 8'hEE;
      bus.pl_valid = (beat != gap_at);
      #1 check_val("pl_ready", 32'(bus.pl_ready), 32'(!bus.busy_in && (beat < ilen)));
      @(posedge clk); #1;
      if (bus.busy_in) stalls++;
      else             beat++;
    end
    bus.start   = 1'b0;
    bus.busy_in = 1'b0;
    check_val("done_pulse", 32'(bus.done),      32'd1);
    check_val("done_data",  32'(bus.data_out),  32'd0);
    check_val("done_valid", 32'(bus.pkt_valid), 32'd0);
    @(posedge clk); #1;
    check_val("done_clear", 32'(bus.done),      32'd0);
    check_val("idle_busy",  32'(bus.tx_busy),   32'd0);
    check_val("sb_empty",   32'(exp_q.size()),  32'd0);
  endtask

  task automatic bad_start(input logic [1:0] addr, input logic [5:0] len);
    bus.start       = 1'b1;
    bus.dest_addr   = addr;
    bus.payload_len = len;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_val("err_pulse",   32'(bus.err),       32'd1);
    check_val("err_busy",    32'(bus.tx_busy),   32'd0);
    check_val("err_valid",   32'(bus.pkt_valid), 32'd0);
    @(posedge clk); #1;
    check_val("err_clear",   32'(bus.err),       32'd0);
    check_val("err_busy2",   32'(bus.tx_busy),   32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.start       = 1'b0;
    bus.dest_addr   = 2'd0;
    bus.payload_len = 6'd0;
    bus.pl_data     = 8'h00;
    bus.pl_valid    = 1'b0;
    bus.busy_in     = 1'b0;
`ifdef ROUTER_TX_PARITY_INJ_EN
    bus.inj_par_err = 1'b0;
`endif
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;

    pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
    run_pkt(2'd1, 6'd3, 1'b0, -1, 0, -1, -1);
    run_pkt(2'd1, 6'd3, 1'b0, 2, 2, -1, -1);

    bad_start(2'd3, 6'd5);
    bad_start(2'd2, 6'd0);

    pay[0] = 8'h11; pay[1] = 8'h22;
    run_pkt(2'd2, 6'd2, 1'b0, -1, 0, 1, -1);
    check_val("underrun_set", 32'(bus.underrun), 32'd1);
    bad_start(2'd3, 6'd1);
    check_val("underrun_sticky", 32'(bus.underrun), 32'd1);
    pay[0] = 8'h5A;
    run_pkt(2'd0, 6'd1, 1'b0, 0, 1, -1, -1);
    check_val("underrun_cleared", 32'(bus.underrun), 32'd0);

    for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
    run_pkt(2'd0, 6'd63, 1'b0, -1, 0, 5, 20);
    run_pkt(2'd2, 6'd7, 1'b0, 3, 1, -1, -1);

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
      run_pkt(2'($urandom_range(0, 2)), 6'($urandom_range(1, 63)), 1'b0,
              int'($urandom_range(0, 8)), int'($urandom_range(0, 3)), -1, -1);
    end
    run_pkt(2'd2, 6'd63, 1'b0, 63, 2, 62, -1);

`ifdef ROUTER_TX_PARITY_INJ_EN
    pay[0] = 8'h55;
    run_pkt(2'd0, 6'd1, 1'b1, -1, 0, -1, -1);
    run_pkt(2'd0, 6'd1, 1'b0, -1, 0, -1, -1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
